// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter in front of a single registered bitwise logic unit.
// Two requesters share the unit; one transaction is in flight at a time
// (IDLE -> EXEC -> RESP) and the result is returned tagged with the owner ID.
module logic_op_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpOr  = 2'b01;
    localparam logic [1:0] OpXor = 2'b10;
    localparam logic [1:0] OpHold = 2'b11;

    state_e           state_q, state_d;
    logic             last_grant_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic             id_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;

    logic grant0, grant1;
    logic accept;
    logic rsp_fire;

    // Grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state_q == StIdle) && grant0;
    assign req1_ready = (state_q == StIdle) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign rsp_fire   = (state_q == StResp) && rsp_ready;

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StExec;
            StExec: state_d = StResp;
            StResp: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted payload and remember who was served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OpAnd;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            a_q          <= grant1 ? req1_a : req0_a;
            b_q          <= grant1 ? req1_b : req0_b;
            op_q         <= grant1 ? req1_op : req0_op;
            id_q         <= grant1;
            last_grant_q <= grant1;
        end
    end

    // Execute stage; hold leaves the previous result (from either requester) untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else if (state_q == StExec) begin
            unique case (op_q)
                OpAnd:  result_q <= a_q & b_q;
                OpOr:   result_q <= a_q | b_q;
                OpXor:  result_q <= a_q ^ b_q;
                OpHold: result_q <= result_q;
                default: result_q <= result_q;
            endcase
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (rsp_fire) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign rsp_id    = id_q;
    assign rsp_data  = result_q;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter. A second instance with CNT_W=2 shares
// all inputs so its counter can be checked for wrap-around.
module tb_logic_op_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic       rsp_ready = 1'b1;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [7:0]  rsp_data;
    logic [15:0] txn_count;

    logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_busy;
    logic [7:0] s_rsp_data;
    logic [1:0] s_txn_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_op_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy), .txn_count(txn_count)
    );

    logic_op_arbiter #(.WIDTH(8), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_data(s_rsp_data), .busy(s_busy), .txn_count(s_txn_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; leaves the bench just after a rising edge.
    task automatic apply_reset();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One request from a single requester with rsp_ready high; checks full latency.
    task automatic single(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] exp_data, input string tag);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        @(negedge clk);
        check({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1 begin req0_valid = 1'b0; req1_valid = 1'b0; end
        @(negedge clk);
        check({tag, "_exec"}, {30'd0, busy, rsp_valid}, 32'd2);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
        check({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp_data});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rsp_ready = 1'b1;
        #1;
        // Reset values
        @(negedge clk);
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_id", {31'd0, rsp_id}, 32'd0);
        check("rst_data", {24'd0, rsp_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnt", {16'd0, txn_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single request
        single(1'b0, 8'hF0, 8'h3C, 2'b00, 8'h30, "single");
        @(negedge clk);
        check("single_cnt", {16'd0, txn_count}, 32'd1);
        check("single_idle", {30'd0, busy, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Tie arbitration plus counter wrap on the 2-bit instance
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hF0; req0_op = 2'b01;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h0F; req1_op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("tie_grant", {30'd0, req1_ready, req0_ready}, (i % 2) ? 32'd2 : 32'd1);
            @(negedge clk);
            check("tie_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
            check("tie_rsp", {23'd0, rsp_valid, rsp_id, rsp_data},
                  (i % 2) ? {23'd0, 1'b1, 1'b1, 8'hF0} : {23'd0, 1'b1, 1'b0, 8'hFF});
            @(posedge clk);
            #1;
            check("tie_cnt", {16'd0, txn_count}, i + 1);
            check("wrap_cnt", {30'd0, s_txn_count}, (i + 1) % 4);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Hold: after reset returns 0, then returns the other requester's last result
        apply_reset();
        single(1'b0, 8'hFF, 8'hFF, 2'b11, 8'h00, "hold_rst");
        single(1'b1, 8'hAA, 8'h55, 2'b10, 8'hFF, "hold_xor");
        single(1'b0, 8'h12, 8'h34, 2'b11, 8'hFF, "hold_prev");

        // Backpressure with req1 pending
        apply_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b00;
        @(posedge clk);
        #1 begin
            req0_valid = 1'b0;
            req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02; req1_op = 2'b01;
        end
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {21'd0, rsp_valid, rsp_id, req1_ready, rsp_data},
                  {21'd0, 1'b1, 1'b0, 1'b0, 8'h30});
            check("bp_cnt", {16'd0, txn_count}, 32'd0);
        end
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_done_cnt", {16'd0, txn_count}, 32'd1);
        check("bp_req1_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_req1_rsp", {22'd0, rsp_valid, rsp_id, rsp_data}, {22'd0, 1'b1, 1'b1, 8'h03});
        @(posedge clk);
        #1;

        // Reset while in EXEC
        check("rexec_precnt", {16'd0, txn_count}, 32'd2);
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h0F; req0_op = 2'b00;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rexec_now", {14'd0, rsp_valid, busy, txn_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rexec_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
        end
        check("rexec_cnt", {16'd0, txn_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
